// File: rtl/cci_mpf_prim_fifo_pkg.sv
// Shared types for the MPF LUTRAM FIFO reader: dequeue-side FSM states and
// the hard ceiling on the almostFull slack.
package cci_mpf_prim_fifo_pkg;

  typedef enum logic [1:0] {
    RUN,
    FLUSH,
    DONE
  } t_fifo_rd_state;

  localparam int unsigned AF_SLACK_MAX = 15;

endpackage

// File: rtl/cci_mpf_prim_fifo_lutram_reader_if.sv
// Dequeue-side FIFO signals and downstream sink beat signals of the reader.
// master = reader, slave = FIFO/sink environment.
interface cci_mpf_prim_fifo_lutram_reader_if #(
  parameter int unsigned N_DATA_BITS = 32
);

  logic [N_DATA_BITS-1:0] in_first;
  logic                   in_notEmpty;
  logic                   in_deq;
  logic                   out_valid;
  logic [N_DATA_BITS-1:0] out_data;
  logic                   out_almostFull;

  modport master (
    input  in_first, in_notEmpty, out_almostFull,
    output in_deq, out_valid, out_data
  );

  modport slave (
    output in_first, in_notEmpty, out_almostFull,
    input  in_deq, out_valid, out_data
  );

endinterface

// File: rtl/cci_mpf_prim_af_credit.sv
// Counts beats forwarded while the sink asserts almostFull and withholds
// permission to send once the slack allowance is used up.
module cci_mpf_prim_af_credit
  import cci_mpf_prim_fifo_pkg::*;
#(
  parameter int unsigned AF_SLACK = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic almostFull,
  input  logic send,
  output logic can_send
);

  localparam int unsigned SLACK_I = (AF_SLACK > AF_SLACK_MAX) ? AF_SLACK_MAX : AF_SLACK;
  localparam logic [3:0]  SLACK   = SLACK_I[3:0];

  logic [3:0] af_sent_q;
  logic [3:0] af_sent_d;

  assign can_send = !almostFull || (af_sent_q < SLACK);

  // Beats sent while almostFull is low never count against the allowance.
  always_comb begin
    af_sent_d = af_sent_q;
    if (!almostFull) begin
      af_sent_d = '0;
    end else if (send && (af_sent_q < SLACK)) begin
      af_sent_d = af_sent_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      af_sent_q <= '0;
    end else begin
      af_sent_q <= af_sent_d;
    end
  end

endmodule

// File: rtl/cci_mpf_prim_fifo_lutram_reader.sv
// Consumer end of an MPF LUTRAM FIFO: pops head entries and forwards them to a
// sink with almostFull slack control, flush support and a sent-beat counter.
module cci_mpf_prim_fifo_lutram_reader
  import cci_mpf_prim_fifo_pkg::*;
#(
  parameter int unsigned N_DATA_BITS = 32,
  parameter int unsigned AF_SLACK    = 2,
  parameter int unsigned N_CNT_BITS  = 16
) (
  input  logic                                  clk,
  input  logic                                  reset,
  cci_mpf_prim_fifo_lutram_reader_if.master     bus,
  input  logic                                  flush_req,
  output logic                                  flush_busy,
  output logic                                  flush_done,
  output logic [N_CNT_BITS-1:0]                 sent_cnt
);

  t_fifo_rd_state          state_q, state_d;
  logic                    out_valid_q, out_valid_d;
  logic [N_DATA_BITS-1:0]  out_data_q, out_data_d;
  logic                    flush_busy_q, flush_busy_d;
  logic                    flush_done_q, flush_done_d;
  logic [N_CNT_BITS-1:0]   sent_cnt_q, sent_cnt_d;
  logic                    can_send;
  logic                    fwd;
  logic                    deq;

  cci_mpf_prim_af_credit #(
    .AF_SLACK (AF_SLACK)
  ) u_credit (
    .clk        (clk),
    .reset      (reset),
    .almostFull (bus.out_almostFull),
    .send       (fwd),
    .can_send   (can_send)
  );

  // fwd marks pops that become sink beats; flush pops are silent discards.
  always_comb begin
    fwd     = 1'b0;
    deq     = 1'b0;
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        fwd = bus.in_notEmpty && can_send && !flush_req;
        deq = fwd;
        if (flush_req) state_d = FLUSH;
      end
      FLUSH: begin
        deq = bus.in_notEmpty;
        if (!bus.in_notEmpty) state_d = DONE;
      end
      DONE:    state_d = RUN;
      default: state_d = RUN;
    endcase
    if (reset) begin
      fwd = 1'b0;
      deq = 1'b0;
    end
    out_valid_d  = fwd;
    out_data_d   = fwd ? bus.in_first : out_data_q;
    sent_cnt_d   = sent_cnt_q + {{(N_CNT_BITS-1){1'b0}}, fwd};
    flush_busy_d = (state_d != RUN);
    flush_done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RUN;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      flush_busy_q <= 1'b0;
      flush_done_q <= 1'b0;
      sent_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      flush_busy_q <= flush_busy_d;
      flush_done_q <= flush_done_d;
      sent_cnt_q   <= sent_cnt_d;
    end
  end

  assign bus.in_deq    = deq;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign flush_busy    = flush_busy_q;
  assign flush_done    = flush_done_q;
  assign sent_cnt      = sent_cnt_q;

endmodule
